// File: rtl/flopoco_fcmp_pipe_if.sv
// rtl/flopoco_fcmp_pipe_if.sv - operand/result handshake bundle for flopoco_fcmp_pipe
interface flopoco_fcmp_pipe_if #(
    parameter int WE = 8,
    parameter int WF = 23
);
    logic              in_valid;
    logic              in_ready;
    logic [WE+WF+2:0]  X;
    logic [WE+WF+2:0]  Y;
    logic [2:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic              result;
    logic              unordered;

    modport master (
        output in_valid, X, Y, op, out_ready,
        input  in_ready, out_valid, result, unordered
    );

    modport slave (
        input  in_valid, X, Y, op, out_ready,
        output in_ready, out_valid, result, unordered
    );
endinterface

// File: rtl/flopoco_fcmp_pipe.sv
// rtl/flopoco_fcmp_pipe.sv - pipelined FloPoCo FP comparator, 8 predicates, 1 or 2 stages
// Optional NaN statistics counter enabled by FCMP_PIPE_STATS_EN.
module flopoco_fcmp_pipe #(
    parameter int WE     = 8,
    parameter int WF     = 23,
    parameter int STAGES = 2,
    parameter int ID     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    flopoco_fcmp_pipe_if.slave bus
`ifdef FCMP_PIPE_STATS_EN
    ,
    output logic [15:0]        nan_count
`endif
);
    localparam int W = WE + WF + 3;
    localparam int M = WE + WF;

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("flopoco_fcmp_pipe %0d: STAGES must be 1 or 2", ID);
        end
    endgenerate

    logic [1:0]   xe, ye;
    logic [M-1:0] mx, my;
    logic [7:0]   cls_n, cls_d, cls_q;   // {x_zero, x_inf, x_nan, x_sign, y_zero, y_inf, y_nan, y_sign}
    logic [2:0]   mag_n, mag_d, mag_q;   // {mlt, mgt, meq}
    logic [2:0]   op_d, op_q;
    logic         s1_valid_d, s1_valid_q;
    logic         down_free, s1_adv, in_ready_w, accept;
    logic         xz, xi, xn, xs, yz, yi, yn, ys, xnrm, ynrm;
    logic         lt, eq, unord, pred;
    logic [2:0]   rx, ry;

    always_comb begin
        xe    = bus.X[W-1 -: 2];
        ye    = bus.Y[W-1 -: 2];
        mx    = bus.X[M-1:0];
        my    = bus.Y[M-1:0];
        cls_n = {xe == 2'b00, xe == 2'b10, xe == 2'b11, bus.X[M],
                 ye == 2'b00, ye == 2'b10, ye == 2'b11, bus.Y[M]};
        mag_n = {mx < my, mx > my, mx == my};
    end

    assign s1_adv     = s1_valid_q && down_free;
    assign in_ready_w = rst_n && (!s1_valid_q || s1_adv);
    assign accept     = bus.in_valid && in_ready_w;
    assign bus.in_ready = in_ready_w;

    always_comb begin
        s1_valid_d = in_ready_w ? bus.in_valid : s1_valid_q;
        cls_d      = cls_q;
        mag_d      = mag_q;
        op_d       = op_q;
        if (accept) begin
            cls_d = cls_n;
            mag_d = mag_n;
            op_d  = bus.op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            cls_q      <= '0;
            mag_q      <= '0;
            op_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            cls_q      <= cls_d;
            mag_q      <= mag_d;
            op_q       <= op_d;
        end
    end

    // Total order over non-NaN classes: -inf, -normal, zero, +normal, +inf.
    always_comb begin
        {xz, xi, xn, xs, yz, yi, yn, ys} = cls_q;
        xnrm  = !(xz || xi || xn);
        ynrm  = !(yz || yi || yn);
        unord = xn || yn;
        rx    = xi ? (xs ? 3'd0 : 3'd4) : (xz ? 3'd2 : (xs ? 3'd1 : 3'd3));
        ry    = yi ? (ys ? 3'd0 : 3'd4) : (yz ? 3'd2 : (ys ? 3'd1 : 3'd3));
        eq    = (xz && yz) || (xi && yi && (xs == ys)) ||
                (xnrm && ynrm && (xs == ys) && mag_q[0]);
        lt    = (rx < ry) ||
                (xnrm && ynrm && (xs == ys) && (xs ? mag_q[1] : mag_q[2]));
        case (op_q)
            3'd0:    pred = !unord && lt;
            3'd1:    pred = !unord && (lt || eq);
            3'd2:    pred = !unord && eq;
            3'd3:    pred = !unord && !lt && !eq;
            3'd4:    pred = !unord && !lt;
            3'd5:    pred = unord || !eq;
            3'd6:    pred = unord;
            default: pred = !unord;
        endcase
    end

    generate
        if (STAGES == 2) begin : g_s2
            logic s2_valid_d, s2_valid_q;
            logic res_d, res_q;
            logic unord_d, unord_q;

            assign down_free = !s2_valid_q || bus.out_ready;

            always_comb begin
                s2_valid_d = s2_valid_q;
                res_d      = res_q;
                unord_d    = unord_q;
                if (down_free) begin
                    s2_valid_d = s1_valid_q;
                    if (s1_valid_q) begin
                        res_d   = pred;
                        unord_d = unord;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    res_q      <= 1'b0;
                    unord_q    <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    res_q      <= res_d;
                    unord_q    <= unord_d;
                end
            end

            assign bus.out_valid = s2_valid_q;
            assign bus.result    = res_q;
            assign bus.unordered = unord_q;
        end else begin : g_s1
            assign down_free     = bus.out_ready;
            assign bus.out_valid = s1_valid_q;
            assign bus.result    = s1_valid_q && pred;
            assign bus.unordered = s1_valid_q && unord;
        end
    endgenerate

`ifdef FCMP_PIPE_STATS_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.out_valid && bus.out_ready && bus.unordered && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign nan_count = cnt_q;
`endif
endmodule

// File: tb/tb_flopoco_fcmp_pipe.sv
// tb/tb_flopoco_fcmp_pipe.sv - directed vector bench for flopoco_fcmp_pipe
module tb_flopoco_fcmp_pipe;
    localparam int WE = 8;
    localparam int WF = 23;

    localparam logic [33:0] P_ONE  = 34'h13F800000;
    localparam logic [33:0] P_TWO  = 34'h140000000;
    localparam logic [33:0] N_ONE  = 34'h1BF800000;
    localparam logic [33:0] N_TWO  = 34'h1C0000000;
    localparam logic [33:0] P_ZERO = 34'h000000000;
    localparam logic [33:0] N_ZERO = 34'h080000000;
    localparam logic [33:0] P_INF  = 34'h27F800000;
    localparam logic [33:0] N_INF  = 34'h2FF800000;
    localparam logic [33:0] QNAN   = 34'h37FC00000;

    typedef struct {
        logic [33:0] x;
        logic [33:0] y;
        logic [2:0]  op;
        logic        res;
        logic        un;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flopoco_fcmp_pipe_if #(.WE(WE), .WF(WF)) bus ();
`ifdef FCMP_PIPE_STATS_EN
    logic [15:0] nc0, nc1;
    flopoco_fcmp_pipe_if #(.WE(WE), .WF(WF)) sb ();
    flopoco_fcmp_pipe #(.WE(WE), .WF(WF), .STAGES(2), .ID(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .nan_count(nc0));
    flopoco_fcmp_pipe #(.WE(WE), .WF(WF), .STAGES(1), .ID(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(sb), .nan_count(nc1));
`else
    flopoco_fcmp_pipe #(.WE(WE), .WF(WF), .STAGES(2), .ID(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [33:0] x, input logic [33:0] y, input logic [2:0] op,
                       input logic res, input logic un);
        vec_t v;
        v.x = x; v.y = y; v.op = op; v.res = res; v.un = un;
        tv.push_back(v);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   sent, recv;
        logic prev_stall, prev_res, saw_full, stale;

        // op codes: 0 LT, 1 LE, 2 EQ, 3 GT, 4 GE, 5 NE, 6 UNORD, 7 ORD
        add(P_ONE,  P_TWO,  3'd0, 1'b1, 1'b0);
        add(P_ONE,  P_TWO,  3'd4, 1'b0, 1'b0);
        add(P_ONE,  P_TWO,  3'd1, 1'b1, 1'b0);
        add(P_ONE,  P_TWO,  3'd3, 1'b0, 1'b0);
        add(P_ONE,  P_TWO,  3'd2, 1'b0, 1'b0);
        add(P_ONE,  P_TWO,  3'd5, 1'b1, 1'b0);
        add(P_TWO,  P_ONE,  3'd3, 1'b1, 1'b0);
        add(P_TWO,  P_ONE,  3'd0, 1'b0, 1'b0);
        add(N_ZERO, P_ZERO, 3'd2, 1'b1, 1'b0);
        add(N_ZERO, P_ZERO, 3'd0, 1'b0, 1'b0);
        add(N_ZERO, P_ZERO, 3'd1, 1'b1, 1'b0);
        add(N_ZERO, P_ZERO, 3'd5, 1'b0, 1'b0);
        add(N_ONE,  P_ZERO, 3'd0, 1'b1, 1'b0);
        add(P_ZERO, N_ONE,  3'd3, 1'b1, 1'b0);
        add(N_INF,  N_INF,  3'd2, 1'b1, 1'b0);
        add(N_INF,  P_INF,  3'd0, 1'b1, 1'b0);
        add(P_INF,  N_INF,  3'd3, 1'b1, 1'b0);
        add(N_ONE,  N_TWO,  3'd0, 1'b0, 1'b0);
        add(N_ONE,  N_TWO,  3'd3, 1'b1, 1'b0);
        add(N_TWO,  N_ONE,  3'd0, 1'b1, 1'b0);
        add(QNAN,   P_ONE,  3'd0, 1'b0, 1'b1);
        add(QNAN,   P_ONE,  3'd5, 1'b1, 1'b1);
        add(QNAN,   P_ONE,  3'd6, 1'b1, 1'b1);
        add(QNAN,   P_ONE,  3'd7, 1'b0, 1'b1);
        add(P_ONE,  QNAN,   3'd4, 1'b0, 1'b1);
        add(P_ONE,  P_TWO,  3'd7, 1'b1, 1'b0);
        add(P_ONE,  P_TWO,  3'd6, 1'b0, 1'b0);
        add(P_ONE,  P_ONE,  3'd4, 1'b1, 1'b0);
        add(P_INF,  P_TWO,  3'd3, 1'b1, 1'b0);
        add(N_INF,  N_ONE,  3'd0, 1'b1, 1'b0);
        add(34'h012345678, P_ZERO, 3'd2, 1'b1, 1'b0);
        add(34'h200000001, P_INF,  3'd2, 1'b1, 1'b0);

        bus.in_valid = 1'b0; bus.X = '0; bus.Y = '0; bus.op = '0; bus.out_ready = 1'b1;
`ifdef FCMP_PIPE_STATS_EN
        sb.in_valid = 1'b0; sb.X = '0; sb.Y = '0; sb.op = '0; sb.out_ready = 1'b1;
`endif
        rst_n = 1'b0;
        step(); step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_unordered", bus.unordered, 0);
        chk("rst_in_ready_low", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", bus.in_ready, 1);

        foreach (tv[i]) begin
            bus.in_valid = 1'b1; bus.X = tv[i].x; bus.Y = tv[i].y; bus.op = tv[i].op;
            #1;
            chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_not_early", i), bus.out_valid, 0);
            step();
            chk($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_result", i), bus.result, tv[i].res);
            chk($sformatf("v%0d_unordered", i), bus.unordered, tv[i].un);
            step();
            chk($sformatf("v%0d_drained", i), bus.out_valid, 0);
        end

        sent = 0; recv = 0; prev_stall = 1'b0; prev_res = 1'b0; saw_full = 1'b0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            bus.in_valid  = (sent < 6);
            if (sent < 6) begin
                bus.X = tv[sent].x; bus.Y = tv[sent].y; bus.op = tv[sent].op;
            end
            #1;
            if (prev_stall) begin
                chk($sformatf("bp_hold_valid_c%0d", c), bus.out_valid, 1);
                chk($sformatf("bp_hold_result_c%0d", c), bus.result, prev_res);
            end
            if (!bus.out_ready && bus.out_valid && !bus.in_ready) saw_full = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp_result_%0d", recv), bus.result, tv[recv].res);
                recv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("bp_all_received", recv, 6);
        chk("bp_in_ready_dropped", saw_full, 1);
        step(); step();

        bus.in_valid = 1'b1; bus.X = tv[0].x; bus.Y = tv[0].y; bus.op = tv[0].op;
        step();
        bus.X = tv[5].x; bus.Y = tv[5].y; bus.op = tv[5].op;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("mf_inflight", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mf_in_ready_in_reset", bus.in_ready, 0);
        step();
        chk("mf_out_valid_cleared", bus.out_valid, 0);
        chk("mf_result_cleared", bus.result, 0);
        chk("mf_unordered_cleared", bus.unordered, 0);
        rst_n = 1'b1;
        #1;
        chk("mf_in_ready_after", bus.in_ready, 1);
        stale = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.out_valid) stale = 1'b1;
        end
        chk("mf_no_stale", stale, 0);

`ifdef FCMP_PIPE_STATS_EN
        for (int i = 0; i < 5; i++) begin
            sb.in_valid = 1'b1; sb.X = (i < 3) ? QNAN : P_TWO; sb.Y = P_ONE; sb.op = 3'd0;
            step();
        end
        sb.in_valid = 1'b0;
        step(); step();
        chk("stats_count3", nc1, 16'd3);
        for (int i = 0; i < 65540; i++) begin
            sb.in_valid = 1'b1; sb.X = QNAN; sb.Y = P_ONE; sb.op = 3'd6;
            step();
        end
        sb.in_valid = 1'b0;
        step(); step();
        chk("stats_saturated", nc1, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
